// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered result/flags and an optional 1-bit-per-clock shifter.
// States: IDLE | waiting for an op ; BUSY | iterative shift in progress ; DONE | result held until out_ready
module alu_seq #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             err_illegal,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SLL = 4'b0001;
  localparam logic [3:0] OP_LT  = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_GT  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SUB = 4'b1000;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept, oor, is_shift, iter_start;
  logic [SHW-1:0]   sh;
  logic [CW-1:0]    k;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] res_nxt;
  logic             carry_nxt, ovf_nxt, err_nxt;
  logic [WIDTH-1:0] work, work_shifted;
  logic [CW-1:0]    cnt;
  logic             dir_right;

  assign accept     = in_valid && in_ready;
  assign sh         = b[SHW-1:0];
  assign oor        = (b >= WIDTH'(WIDTH));
  // out-of-range amounts iterate WIDTH times, which shifts everything out
  assign k          = oor ? CW'(WIDTH) : {1'b0, sh};
  assign sum        = {1'b0, a} + {1'b0, b};
  assign diff       = {1'b0, a} - {1'b0, b};
  assign is_shift   = (op == OP_SLL) || (op == OP_SRL);
  assign iter_start = (SHIFT_MODE != 0) && is_shift && (k != '0);
  assign work_shifted = dir_right ? (work >> 1) : (work << 1);

  always_comb begin
    res_nxt   = '0;
    carry_nxt = 1'b0;
    ovf_nxt   = 1'b0;
    err_nxt   = 1'b0;
    case (op)
      OP_ADD: begin
        {carry_nxt, res_nxt} = sum;
        ovf_nxt = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_nxt   = diff[WIDTH-1:0];
        carry_nxt = ~diff[WIDTH];
        ovf_nxt   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL:  res_nxt = oor ? '0 : (a << sh);
      OP_SRL:  res_nxt = oor ? '0 : (a >> sh);
      OP_LT:   res_nxt = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_GT:   res_nxt = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_AND:  res_nxt = a & b;
      OP_OR:   res_nxt = a | b;
      OP_XOR:  res_nxt = a ^ b;
      default: err_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = iter_start ? BUSY : DONE;
      BUSY: if (cnt <= CW'(1)) state_nxt = DONE;
      DONE: begin
        if (accept)         state_nxt = iter_start ? BUSY : DONE;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result      <= '0;
      carry       <= 1'b0;
      overflow    <= 1'b0;
      err_illegal <= 1'b0;
      work        <= '0;
      cnt         <= '0;
      dir_right   <= 1'b0;
    end else if (accept && iter_start) begin
      work      <= a;
      cnt       <= k;
      dir_right <= (op == OP_SRL);
    end else if (accept) begin
      result      <= res_nxt;
      carry       <= carry_nxt;
      overflow    <= ovf_nxt;
      err_illegal <= err_nxt;
    end else if (state == BUSY) begin
      work <= work_shifted;
      cnt  <= cnt - CW'(1);
      if (cnt <= CW'(1)) begin
        result      <= work_shifted;
        carry       <= 1'b0;
        overflow    <= 1'b0;
        err_illegal <= 1'b0;
      end
    end
  end

  // zero tracks the held result and is only meaningful alongside out_valid
  assign zero = out_valid && (result == '0);

endmodule
